// File: rtl/reg_f_arb.sv
// reg_f_arb: two-requester round-robin arbiter sharing the single reg_f access port
module reg_f_arb #(
    parameter int  WIDTH = 8,
    parameter int  SIZE  = 9,
    localparam int SW    = $clog2(SIZE)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             A_REQ,
    input  logic             A_WR,
    input  logic [SW-1:0]    A_SEL,
    input  logic [WIDTH-1:0] A_DATA,
    output logic             A_GNT,
    output logic [WIDTH-1:0] A_RDATA,
    output logic             A_RVALID,
    output logic             A_ERR,
    input  logic             B_REQ,
    input  logic             B_WR,
    input  logic [SW-1:0]    B_SEL,
    input  logic [WIDTH-1:0] B_DATA,
    output logic             B_GNT,
    output logic [WIDTH-1:0] B_RDATA,
    output logic             B_RVALID,
    output logic             B_ERR,
    output logic             RF_EN,
    output logic             RF_WR,
    output logic [SW-1:0]    RF_SEL,
    output logic [WIDTH-1:0] RF_IN,
    input  logic [WIDTH-1:0] RF_OUT
);
    typedef enum logic [1:0] {IDLE, ISSUE_A, ISSUE_B} state_t;

    localparam logic [SW:0] SIZE_W = (SW+1)'(SIZE);

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic             wr_q, wr_d;
    logic [SW-1:0]    sel_q, sel_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
    logic             a_err_q, a_err_d, b_err_q, b_err_d;
    logic [WIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic             a_elig, b_elig, a_win, b_win, oor;
    logic [WIDTH-1:0] rd_val;

    // arbitrate (owner of the current issue slot is masked), latch the winner and route responses
    always_comb begin
        a_elig     = A_REQ && (state_q != ISSUE_A);
        b_elig     = B_REQ && (state_q != ISSUE_B);
        a_win      = a_elig && (!b_elig || last_q);
        b_win      = b_elig && !a_win;
        state_d    = a_win ? ISSUE_A : (b_win ? ISSUE_B : IDLE);
        last_d     = a_win ? 1'b0 : (b_win ? 1'b1 : last_q);
        wr_d       = a_win ? A_WR : (b_win ? B_WR : wr_q);
        sel_d      = a_win ? A_SEL : (b_win ? B_SEL : sel_q);
        data_d     = a_win ? A_DATA : (b_win ? B_DATA : data_q);
        oor        = {1'b0, sel_q} >= SIZE_W;
        rd_val     = oor ? '0 : RF_OUT;
        a_rvalid_d = (state_q == ISSUE_A) && !wr_q;
        b_rvalid_d = (state_q == ISSUE_B) && !wr_q;
        a_err_d    = (state_q == ISSUE_A) && oor;
        b_err_d    = (state_q == ISSUE_B) && oor;
        a_rdata_d  = a_rvalid_d ? rd_val : a_rdata_q;
        b_rdata_d  = b_rvalid_d ? rd_val : b_rdata_q;
    end

    // state, issue register and response registers; last_q = 1 means B was granted last
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            wr_q       <= 1'b0;
            sel_q      <= '0;
            data_q     <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_err_q    <= 1'b0;
            b_err_q    <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            wr_q       <= wr_d;
            sel_q      <= sel_d;
            data_q     <= data_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_err_q    <= a_err_d;
            b_err_q    <= b_err_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign A_GNT    = state_q == ISSUE_A;
    assign B_GNT    = state_q == ISSUE_B;
    assign A_RVALID = a_rvalid_q;
    assign B_RVALID = b_rvalid_q;
    assign A_ERR    = a_err_q;
    assign B_ERR    = b_err_q;
    assign A_RDATA  = a_rdata_q;
    assign B_RDATA  = b_rdata_q;
    assign RF_EN    = (state_q != IDLE) && !oor;
    assign RF_WR    = RF_EN && wr_q;
    assign RF_SEL   = sel_q;
    assign RF_IN    = data_q;
endmodule

// File: tb/tb_reg_f_arb.sv
// tb_reg_f_arb: randomized and directed checks of reg_f_arb against a transaction-level model
module tb_reg_f_arb;
    localparam int WIDTH = 8;
    localparam int SIZE  = 9;
    localparam int SW    = $clog2(SIZE);

    typedef struct packed {
        logic             wr;
        logic [SW-1:0]    sel;
        logic [WIDTH-1:0] data;
    } txn_t;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             req [2];
    logic             wr [2];
    logic [SW-1:0]    sel [2];
    logic [WIDTH-1:0] data [2];
    logic             A_GNT, B_GNT, A_RVALID, B_RVALID, A_ERR, B_ERR;
    logic [WIDTH-1:0] A_RDATA, B_RDATA;
    logic             RF_EN, RF_WR;
    logic [SW-1:0]    RF_SEL;
    logic [WIDTH-1:0] RF_IN, RF_OUT;

    // environment register file: 16 entries so out-of-range indices return recognisable junk
    logic [WIDTH-1:0] rf_mem [16];
    // reference contents, updated only by the model
    logic [WIDTH-1:0] ref_mem [SIZE];

    // per-requester transaction programs
    txn_t prog [2][256];
    int   head [2];
    int   tail [2];
    int   gap [2];
    int   gap_max = 0;

    // model state: who holds the current issue slot (0 none, 1 A, 2 B) and what it carries
    int               cur = 0;
    int               prev = 0;
    txn_t             cur_t = '0;
    logic             last_b = 1'b1;
    logic [1:0]       exp_rv = '0;
    logic [1:0]       exp_err = '0;
    logic [WIDTH-1:0] exp_rd [2];

    int checks = 0;
    int errors = 0;

    reg_f_arb #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .CLK(CLK), .RST(RST),
        .A_REQ(req[0]), .A_WR(wr[0]), .A_SEL(sel[0]), .A_DATA(data[0]),
        .A_GNT(A_GNT), .A_RDATA(A_RDATA), .A_RVALID(A_RVALID), .A_ERR(A_ERR),
        .B_REQ(req[1]), .B_WR(wr[1]), .B_SEL(sel[1]), .B_DATA(data[1]),
        .B_GNT(B_GNT), .B_RDATA(B_RDATA), .B_RVALID(B_RVALID), .B_ERR(B_ERR),
        .RF_EN(RF_EN), .RF_WR(RF_WR), .RF_SEL(RF_SEL), .RF_IN(RF_IN), .RF_OUT(RF_OUT)
    );

    always #5 CLK = ~CLK;

    assign RF_OUT = rf_mem[RF_SEL];

    always @(posedge CLK) if (RF_EN && RF_WR) rf_mem[RF_SEL] <= RF_IN;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int s, input logic w, input logic [SW-1:0] sl, input logic [WIDTH-1:0] d);
        prog[s][tail[s]] = '{w, sl, d};
        tail[s]++;
    endtask

    // abstract model, advanced at each rising edge with the inputs that were present
    task automatic model_update();
        int         w;
        logic       oor, ea, eb;
        logic [1:0] nrv, nerr;
        nrv  = '0;
        nerr = '0;
        prev = cur;
        ea   = req[0] && (cur != 1);
        eb   = req[1] && (cur != 2);
        if (cur != 0) begin
            w   = cur - 1;
            oor = cur_t.sel >= SIZE;
            nerr[w] = oor;
            if (!cur_t.wr) begin
                nrv[w] = 1'b1;
                if (!RST) exp_rd[w] = oor ? '0 : ref_mem[cur_t.sel];
            end else if (!oor) ref_mem[cur_t.sel] = cur_t.data;
        end
        if (RST) begin
            exp_rv    = '0;
            exp_err   = '0;
            exp_rd[0] = '0;
            exp_rd[1] = '0;
            last_b    = 1'b1;
            cur       = 0;
            cur_t     = '0;
        end else begin
            exp_rv  = nrv;
            exp_err = nerr;
            if (ea && (!eb || last_b)) begin
                cur = 1; last_b = 1'b0; cur_t = '{wr[0], sel[0], data[0]};
            end else if (eb) begin
                cur = 2; last_b = 1'b1; cur_t = '{wr[1], sel[1], data[1]};
            end else cur = 0;
        end
    endtask

    // requesters: hold a request until its grant cycle is over, then move on
    task automatic drive();
        for (int s = 0; s < 2; s++) begin
            if (prev == s + 1) begin
                head[s]++;
                gap[s] = $urandom_range(gap_max, 0);
            end
            if (gap[s] > 0 || head[s] >= tail[s]) begin
                if (gap[s] > 0) gap[s]--;
                req[s]  = 1'b0;
                wr[s]   = 1'($urandom);
                sel[s]  = SW'($urandom);
                data[s] = WIDTH'($urandom);
            end else begin
                req[s] = 1'b1;
                {wr[s], sel[s], data[s]} = prog[s][head[s]];
            end
        end
    endtask

    task automatic compare();
        logic en_e;
        en_e = (cur != 0) && (cur_t.sel < SIZE);
        check("a_gnt", A_GNT, cur == 1);
        check("b_gnt", B_GNT, cur == 2);
        check("a_rvalid", A_RVALID, exp_rv[0]);
        check("b_rvalid", B_RVALID, exp_rv[1]);
        check("a_err", A_ERR, exp_err[0]);
        check("b_err", B_ERR, exp_err[1]);
        check("a_rdata", A_RDATA, exp_rd[0]);
        check("b_rdata", B_RDATA, exp_rd[1]);
        check("rf_en", RF_EN, en_e);
        check("rf_wr", RF_WR, en_e && cur_t.wr);
        check("rf_sel", RF_SEL, cur_t.sel);
        check("rf_in", RF_IN, cur_t.data);
    endtask

    task automatic step();
        @(posedge CLK);
        model_update();
        #1 drive();
        @(negedge CLK);
        compare();
    endtask

    task automatic drain();
        int n = 0;
        while ((head[0] < tail[0] || head[1] < tail[1] || cur != 0) && n < 2000) begin
            step();
            n++;
        end
        check("drain", n < 2000, 1);
        step();
        step();
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16; i++) rf_mem[i] = 8'hEE;
        for (int i = 0; i < SIZE; i++) begin
            rf_mem[i]  = WIDTH'(8'h80 + i);
            ref_mem[i] = WIDTH'(8'h80 + i);
        end
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        head = '{0, 0};
        tail = '{0, 0};
        gap  = '{0, 0};
        // reset with both requesting, then A write/read of SEL 3
        push(0, 1'b1, 3, 8'h5A);
        push(0, 1'b0, 3, 8'h00);
        push(1, 1'b0, 8, 8'h00);
        drive();
        repeat (3) step();
        RST = 1'b0;
        drain();
        // contention: A writes SEL i, B keeps reading SEL 8
        for (int i = 0; i < SIZE; i++) begin
            push(0, 1'b1, SW'(i), WIDTH'(i));
            push(1, 1'b0, 8, 8'h00);
        end
        drain();
        // B fills and reads back every register
        for (int i = 0; i < SIZE; i++) push(1, 1'b1, SW'(i), WIDTH'(8'h10 + i));
        for (int i = 0; i < SIZE; i++) push(1, 1'b0, SW'(i), 8'h00);
        drain();
        // out-of-range write, readback, out-of-range read
        push(0, 1'b1, 9, 8'hFF);
        for (int i = 0; i < SIZE; i++) push(0, 1'b0, SW'(i), 8'h00);
        push(0, 1'b0, 15, 8'h00);
        drain();
        // reset landing on the issue cycle of a B read
        push(1, 1'b0, 2, 8'h00);
        n = 0;
        while (cur != 2 && n < 50) begin
            step();
            n++;
        end
        check("b_issue_seen", cur, 2);
        RST = 1'b1;
        step();
        RST = 1'b0;
        push(0, 1'b0, 4, 8'h00);
        push(1, 1'b0, 5, 8'h00);
        drain();
        // random traffic with gaps, including out-of-range indices
        gap_max = 2;
        for (int i = 0; i < 120; i++) begin
            push(0, 1'($urandom), SW'($urandom_range(15, 0)), WIDTH'($urandom));
            push(1, 1'($urandom), SW'($urandom_range(SIZE, 0)), WIDTH'($urandom));
        end
        drain();
        for (int i = 0; i < SIZE; i++) check($sformatf("mem%0d", i), rf_mem[i], ref_mem[i]);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_f_arb.md
# reg_f_arb

Two-requester round-robin arbiter that shares the single access port of the `reg_f` register file between requester A (core datapath) and requester B (debug/loader). It registers the winning request, drives the `reg_f` control lines for exactly one cycle and returns read data with a valid strobe. It also rejects out-of-range register indices so that `reg_f` never sees `SEL >= SIZE`.

## Interface
Parameters:
- WIDTH, 8, data width; must match `reg_f` WIDTH.
- SIZE, 9, register count; must match `reg_f` SIZE; SW = $clog2(SIZE).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- A_REQ  in  1  request from A; held with A_WR, A_SEL and A_DATA stable until A_GNT.
- A_WR  in  1  1 = write, 0 = read.
- A_SEL  in  SW  register index.
- A_DATA  in  WIDTH  write data.
- A_GNT  out  1  one-cycle grant pulse, high during the issue cycle.
- A_RDATA  out  WIDTH  read data, valid while A_RVALID is high.
- A_RVALID  out  1  one-cycle read-data strobe.
- A_ERR  out  1  one-cycle strobe: the granted request had SEL >= SIZE.
- B_REQ, B_WR, B_SEL, B_DATA, B_GNT, B_RDATA, B_RVALID, B_ERR: same as the A_* ports, for requester B.
- RF_EN  out  1  drives `reg_f` EN.
- RF_WR  out  1  drives `reg_f` WR.
- RF_SEL  out  SW  drives `reg_f` SEL.
- RF_IN  out  WIDTH  drives `reg_f` IN.
- RF_OUT  in  WIDTH  `reg_f` OUT; combinational read of RF_SEL.

## Operation
- Arbitration runs every cycle on the requests that are eligible.
  - In the issue cycle, the requester currently being granted is masked, because its REQ is still held.
  - If only one requester is eligible, it wins.
  - If both are eligible, the one not granted last wins.
- LAST pointer: 1 bit, updated on every grant; reset value = B, so A wins the first tie.
- Issue register: on the edge after arbitration, it latches owner, WR, SEL and DATA, and sets ISSUE=1.
  - ISSUE is high for one cycle only.
  - It is re-set on the next edge only if the other requester won.
- State per cycle: IDLE (ISSUE=0) or ISSUE_A / ISSUE_B.
  - IDLE→ISSUE_x on a win by x.
  - ISSUE_A→ISSUE_B if B is eligible, else IDLE.
  - ISSUE_B→ISSUE_A if A is eligible, else IDLE.
  - ISSUE_x never goes directly to ISSUE_x.
- Range check happens at issue time. If latched SEL >= SIZE:
  - RF_EN = 0, so nothing is written to `reg_f`.
  - GNT is still pulsed.
  - ERR pulses one cycle later, together with RVALID for reads.
  - RDATA = 0.
- Read path: at the end of the issue cycle, RF_OUT (or 0 if out of range) is captured into the owner's RDATA, and the owner's RVALID is set for one cycle.
- RDATA holds its last value until the next read completes for that requester.
- Write path: `reg_f` commits RF_IN at the edge ending the issue cycle. There is no RVALID for writes.
- RF_WR = 0 whenever RF_EN = 0. RF_SEL and RF_IN are held at their last values when idle.

## Timing
- Cycle N: REQ sampled high and the requester wins.
- Cycle N+1 (issue cycle):
  - GNT = 1.
  - RF_EN = 1 (in range), RF_WR, RF_SEL and RF_IN are valid.
- Write data is visible in `reg_f` from N+2.
- Read: RVALID = 1 and RDATA is valid in cycle N+2. Request-to-data latency is 2 cycles.
- Throughput:
  - Alternating A/B gives one access per cycle.
  - A single requester gets at most one access every 2 cycles: its REQ is masked in its own issue cycle.
- Requester rules:
  - It may deassert or change REQ and its fields in the cycle after GNT.
  - A REQ still high after GNT is a new request.
- Reset values:
  - A_GNT, B_GNT, A_RVALID, B_RVALID, A_ERR, B_ERR, RF_EN, RF_WR = 0.
  - A_RDATA, B_RDATA, RF_SEL, RF_IN = 0.
  - ISSUE = 0, LAST = B.
- Reset mid-operation:
  - An issue cycle coinciding with RST=1 still commits its write to `reg_f`, because the arbiter cannot retract RF_EN within the cycle.
  - The RVALID/ERR that would follow is suppressed.
  - Requests present while RST=1 are ignored. Arbitration resumes in the first cycle with RST=0.
- Simultaneous new requests from both A and B: only one is granted. The loser keeps REQ high and wins in the next issue slot.

## Test plan
- Reset: hold RST 3 cycles with both REQ high → all outputs 0 during reset; first grant after release goes to A (LAST=B).
- Single write then read by A: A writes SEL=3, DATA=8'h5A; then A reads SEL=3 → A_GNT pulses are 2 cycles apart; A_RVALID=1 with A_RDATA=8'h5A exactly 2 cycles after the read REQ is sampled.
- Contention: A and B both request continuously, A writing SEL=i with DATA=i, B reading SEL=8 → grants alternate A, B, A, B…; RF_EN stays high every cycle; no requester is granted twice in a row.
- Fill and readback: B writes 8'h10+i to SEL 0…8, then reads all 9 → each B_RDATA = 8'h10+i; A_RVALID never asserts.
- Out of range: A writes SEL=9 (SIZE=9) with DATA=8'hFF → A_GNT=1 and RF_EN=0 in the issue cycle; A_ERR=1 one cycle later; a readback of SEL 0…8 shows no change. A read of SEL=15 → A_RVALID=1, A_ERR=1, A_RDATA=0.
- Reset during issue: assert RST in the issue cycle of a B read of SEL=2 → B_RVALID stays 0; after release, arbitration restarts from A.
